// File: rtl/ual_pkg.sv
// rtl/ual_pkg.sv - opcode constants and FSM state type for the UAL_MC arithmetic/logic unit
package ual_pkg;

  localparam logic [2:0] OP_NOR  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_RSV5 = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_RSV7 = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } ual_state_t;

endpackage

// File: rtl/ual_mul_seq.sv
// rtl/ual_mul_seq.sv - shift-add multiply datapath: operand registers, accumulator, step counter
module ual_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   r1,
  input  logic [WIDTH-1:0]   accu,
  output logic [2*WIDTH-1:0] product_nxt,
  output logic               last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  // The value the accumulator takes on this step; on the final step it is the full product.
  assign product_nxt = acc + (mplier[0] ? mcand : '0);
  assign last        = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, r1};
      mplier <= accu;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      acc    <= product_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ual_mc.sv
// rtl/ual_mc.sv - arithmetic/logic unit with single-cycle ops and a multi-cycle shift-add multiply
module ual_mc
  import ual_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             CE,
  input  logic             start,
  input  logic [2:0]       sel_UAL,
  input  logic [WIDTH-1:0] DATA_R1,
  input  logic [WIDTH-1:0] DATA_ACCU,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  ual_state_t state, state_nxt;

  logic               is_mul_op;
  logic               accept;
  logic               load;
  logic               alu_done;
  logic               step;
  logic               mul_done;
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH:0]     ext_r1;
  logic [WIDTH:0]     ext_accu;
  logic [WIDTH:0]     alu_wide;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;

  assign is_mul_op = MUL_EN && (sel_UAL == OP_MUL);
  assign accept    = (state == ST_IDLE) && CE && start;
  assign alu_done  = accept && !is_mul_op;
  assign mul_done  = step && mul_last;

  generate
    if (MUL_EN) begin : g_mul
      ual_mul_seq #(.WIDTH(WIDTH)) u_mul_seq (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .step        (step),
        .r1          (DATA_R1),
        .accu        (DATA_ACCU),
        .product_nxt (mul_product),
        .last        (mul_last)
      );
    end else begin : g_no_mul
      assign mul_product = '0;
      assign mul_last    = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && is_mul_op) state_nxt = ST_MUL;
      ST_MUL:  if (mul_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_MUL);
    load = accept && is_mul_op;
    step = (state == ST_MUL) && CE;
  end

  // Operands widened by one bit so the carry of ADD and the borrow of SUB both land in bit WIDTH.
  always_comb begin
    ext_r1    = {1'b0, DATA_R1};
    ext_accu  = {1'b0, DATA_ACCU};
    alu_wide  = '0;
    alu_carry = 1'b0;
    case (sel_UAL)
      OP_NOR: alu_wide = {1'b0, ~(DATA_R1 | DATA_ACCU)};
      OP_AND: alu_wide = {1'b0, DATA_R1 & DATA_ACCU};
      OP_ADD: begin
        alu_wide  = ext_r1 + ext_accu;
        alu_carry = alu_wide[WIDTH];
      end
      OP_SUB: begin
        alu_wide  = ext_accu - ext_r1;
        alu_carry = alu_wide[WIDTH];
      end
      OP_XOR: alu_wide = {1'b0, DATA_R1 ^ DATA_ACCU};
      default: alu_wide = '0;
    endcase
    alu_res = alu_wide[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      DATA_OUT <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // Both completion sources require CE, so a pending pulse always drops after one cycle.
      done <= alu_done || mul_done;
      if (alu_done) begin
        DATA_OUT <= alu_res;
        carry    <= alu_carry;
        zero     <= (alu_res == '0);
      end else if (mul_done) begin
        DATA_OUT <= mul_product[WIDTH-1:0];
        carry    <= |mul_product[2*WIDTH-1:WIDTH];
        zero     <= (mul_product[WIDTH-1:0] == '0);
      end
    end
  end

endmodule

// File: tb/tb_ual_mc.sv
// tb/tb_ual_mc.sv - randomized and directed self-checking bench for ual_mc against an arithmetic model
module tb_ual_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        CE;
  logic        start;
  logic [2:0]  sel_UAL;
  logic [15:0] DATA_R1;
  logic [15:0] DATA_ACCU;
  logic [15:0] DATA_OUT;
  logic        carry;
  logic        zero;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ual_mc #(.WIDTH(16), .MUL_EN(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .CE        (CE),
    .start     (start),
    .sel_UAL   (sel_UAL),
    .DATA_R1   (DATA_R1),
    .DATA_ACCU (DATA_ACCU),
    .DATA_OUT  (DATA_OUT),
    .carry     (carry),
    .zero      (zero),
    .busy      (busy),
    .done      (done)
  );

  // Returns {carry, result} from plain unsigned arithmetic on the operand values.
  function automatic logic [16:0] model(input logic [2:0] op, input logic [15:0] r1, input logic [15:0] acc);
    longint a = longint'(r1);
    longint b = longint'(acc);
    longint m = 65536;
    longint res = 0;
    logic   c = 1'b0;
    case (op)
      3'd0: res = (m - 1) - (a | b);
      3'd1: res = a & b;
      3'd2: begin res = (a + b) % m; c = (a + b) >= m; end
      3'd3: begin res = (b - a + m) % m; c = b < a; end
      3'd4: res = a ^ b;
      3'd6: begin res = (a * b) % m; c = (a * b) >= m; end
      default: res = 0;
    endcase
    return {c, res[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input logic [16:0] exp);
    chk({tag, ".out"}, 32'(DATA_OUT), 32'(exp[15:0]));
    chk({tag, ".carry"}, 32'(carry), 32'(exp[16]));
    chk({tag, ".zero"}, 32'(zero), 32'(exp[15:0] == 16'h0));
  endtask

  task automatic single_op(input string tag, input logic [2:0] op, input logic [15:0] r1, input logic [15:0] acc);
    logic [16:0] exp;
    exp = model(op, r1, acc);
    sel_UAL = op; DATA_R1 = r1; DATA_ACCU = acc; start = 1'b1; CE = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".done"}, 32'(done), 32'd1);
    check_result(tag, exp);
    tick();
    chk({tag, ".done_drop"}, 32'(done), 32'd0);
    chk({tag, ".held"}, 32'(DATA_OUT), 32'(exp[15:0]));
  endtask

  task automatic mul_op(input string tag, input logic [15:0] r1, input logic [15:0] acc,
                        input int stall_at, input int stall_len, input bit inject);
    logic [16:0] exp;
    int n;
    exp = model(3'd6, r1, acc);
    sel_UAL = 3'd6; DATA_R1 = r1; DATA_ACCU = acc; start = 1'b1; CE = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".busy_start"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 200) begin
      CE = !(n >= stall_at && n < stall_at + stall_len);
      if (inject && n >= 3 && n < 6) begin
        start = 1'b1; sel_UAL = 3'($urandom_range(0, 4));
        DATA_R1 = 16'($urandom); DATA_ACCU = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
      chk({tag, ".busy"}, 32'(busy), 32'(!done));
    end
    CE = 1'b1; start = 1'b0;
    chk({tag, ".cycles"}, 32'(n), 32'(16 + stall_len));
    check_result(tag, exp);
    tick();
    chk({tag, ".done_drop"}, 32'(done), 32'd0);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [16:0] exp;
    logic [15:0] held;
    reset = 1'b1; CE = 1'b0; start = 1'b0; sel_UAL = 3'd0; DATA_R1 = '0; DATA_ACCU = '0;
    tick(); tick();
    chk("rst.out", 32'(DATA_OUT), 32'd0);
    chk("rst.carry", 32'(carry), 32'd0);
    chk("rst.zero", 32'(zero), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    reset = 1'b0; CE = 1'b1;
    tick();

    single_op("add_wrap", 3'd2, 16'hFFFF, 16'h0001);
    chk("add_wrap.lit", 32'({carry, zero, DATA_OUT}), 32'h3_0000);
    single_op("sub_borrow", 3'd3, 16'h0005, 16'h0003);
    chk("sub_borrow.lit", 32'({carry, zero, DATA_OUT}), 32'h2_FFFE);
    single_op("rsv7", 3'd7, 16'h1234, 16'hABCD);
    chk("rsv7.lit", 32'({carry, zero, DATA_OUT}), 32'h1_0000);
    single_op("rsv5", 3'd5, 16'hFFFF, 16'hFFFF);

    for (int i = 0; i < 20; i++) begin
      single_op("rand_op", 3'($urandom_range(0, 5)), 16'($urandom), 16'($urandom));
    end

    // Consecutive starts, one completion per cycle.
    CE = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sel_UAL = 3'($urandom_range(0, 4)); DATA_R1 = 16'($urandom); DATA_ACCU = 16'($urandom);
      exp = model(sel_UAL, DATA_R1, DATA_ACCU);
      start = 1'b1;
      tick();
      chk("b2b.done", 32'(done), 32'd1);
      check_result("b2b", exp);
    end
    start = 1'b0;
    tick();
    chk("b2b.done_drop", 32'(done), 32'd0);

    // A start with CE low must leave everything untouched.
    held = DATA_OUT;
    sel_UAL = 3'd0; DATA_R1 = 16'h0; DATA_ACCU = 16'h0; start = 1'b1; CE = 1'b0;
    tick(); tick();
    chk("ce_low.done", 32'(done), 32'd0);
    chk("ce_low.out", 32'(DATA_OUT), 32'(held));
    start = 1'b0; CE = 1'b1;
    tick();

    mul_op("mul_ovf", 16'h0100, 16'h0300, 1000, 0, 1'b1);
    chk("mul_ovf.lit", 32'({carry, zero, DATA_OUT}), 32'h3_0000);
    mul_op("mul_stall", 16'h0007, 16'h0006, 4, 5, 1'b0);
    chk("mul_stall.lit", 32'({carry, DATA_OUT}), 32'h0_002A);

    for (int i = 0; i < 4; i++) begin
      mul_op("mul_rand", 16'($urandom), 16'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 4)), 1'b0);
    end

    // Abort a multiply after 8 steps with an asynchronous reset.
    sel_UAL = 3'd6; DATA_R1 = 16'h00F3; DATA_ACCU = 16'h0011; start = 1'b1; CE = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("abort.busy_before", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort.out", 32'(DATA_OUT), 32'd0);
    chk("abort.flags", 32'({carry, zero, busy, done}), 32'd0);
    tick(); tick();
    chk("abort.done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("abort.no_done", 32'(done), 32'd0);
    end

    single_op("nor_after", 3'd0, 16'h0F0F, 16'h00FF);
    chk("nor_after.lit", 32'({carry, DATA_OUT}), 32'h0_F000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
